ram_responder: RTL and testbench

Synchronous single-port RAM responder that sits on the slave end of the team's RAM bus (`ram_cs_i`/`ram_we_i`/`ram_addr_i`/`ram_data_i` → `ram_data_o`). It serves the bus the driver agent initiates. After reset it clears its storage with a sequential init engine. It then serves writes in zero cycles and reads with a fixed, parameterised latency. It flags readiness and read-data validity, and counts accesses that arrive while it is not ready.

---
 rtl/ram_pkg.sv | 17 +
 rtl/ram_rd_pipe.sv | 52 +++++
 rtl/ram_responder.sv | 121 ++++++++++++
 tb/tb_ram_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the RAM bus slave (ram_responder and its read pipeline).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_pkg;

    // INIT clears storage after reset; RUN serves the bus until the next reset.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ram_state_e;

    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 32;
    localparam int READ_LAT_DEF = 1;
    localparam int DROP_CNT_W   = 8;

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-return pipeline: READ_LAT stages of {valid, data} plus the output-hold register.
// Latency: a word entering at edge N is presented on rsp_dat/rsp_vld at edge N+READ_LAT.
// Backpressure: none; accepts one word per cycle and never stalls. Reset flushes every stage.
//
// Ports:
//   clk_i, rst_n_i    clock and synchronous active-low reset
//   rd_vld, rd_dat    word sampled from the array this cycle
//   rsp_vld, rsp_dat  one-cycle valid pulse and held read data
module ram_rd_pipe #(
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              rd_vld,
    input  logic [DATA_W-1:0] rd_dat,
    output logic              rsp_vld,
    output logic [DATA_W-1:0] rsp_dat
);

    logic              vld_q [READ_LAT];
    logic [DATA_W-1:0] dat_q [READ_LAT];
    logic              rsp_vld_q;
    logic [DATA_W-1:0] rsp_dat_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < READ_LAT; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
        end else begin
            vld_q[0] <= rd_vld;
            dat_q[0] <= rd_dat;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
            rsp_vld_q <= vld_q[READ_LAT-1];
            // Data only moves on a valid word so the output holds the last read value.
            if (vld_q[READ_LAT-1]) begin
                rsp_dat_q <= dat_q[READ_LAT-1];
            end
        end
    end

    assign rsp_vld = rsp_vld_q;
    assign rsp_dat = rsp_dat_q;

endmodule

// File: rtl/ram_responder.sv
// Single-port RAM bus slave: clears its array after reset, then serves zero-cycle writes and pipelined reads.
// Latency: write visible to a read on the next edge; read at edge N returns at edge N+READ_LAT.
// Backpressure: none on the bus; accesses while not ready are dropped and counted (saturating).
//
// Ports:
//   clk_i, rst_n_i          clock and synchronous active-low reset
//   ram_cs_i, ram_we_i      access strobe and write/read select
//   ram_addr_i, ram_data_i  word address (modulo depth) and write data
//   ram_data_o, ram_rvalid_o  read data (held) and one-cycle read-valid pulse
//   ram_ready_o             registered RUN-state flag
//   drop_cnt_o              saturating count of accesses ignored during INIT
module ram_responder
    import ram_pkg::*;
#(
    parameter int               ADDR_W   = ADDR_W_DEF,
    parameter int               DATA_W   = DATA_W_DEF,
    parameter int               READ_LAT = READ_LAT_DEF,   // legal 1..4
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  ram_cs_i,
    input  logic                  ram_we_i,
    input  logic [ADDR_W-1:0]     ram_addr_i,
    input  logic [DATA_W-1:0]     ram_data_i,
    output logic [DATA_W-1:0]     ram_data_o,
    output logic                  ram_rvalid_o,
    output logic                  ram_ready_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    ram_state_e            state_q;
    logic [ADDR_W-1:0]     init_cnt_q;
    logic                  ready_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    logic [DATA_W-1:0]     mem [DEPTH];

    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_dat;
    logic                  rd_en;
    logic [DATA_W-1:0]     rd_dat;

    // The single write port is shared: the init engine owns it in INIT, the bus owns it in RUN.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = ram_addr_i;
        wr_dat  = ram_data_i;
        rd_en   = 1'b0;
        if (rst_n_i) begin
            if (state_q == INIT) begin
                wr_en   = 1'b1;
                wr_addr = init_cnt_q;
                wr_dat  = INIT_VAL;
            end else begin
                wr_en = ram_cs_i & ram_we_i;
                rd_en = ram_cs_i & ~ram_we_i;
            end
        end
    end

    assign rd_dat = mem[ram_addr_i];

    // Storage has no reset; contents are defined once INIT has swept every word.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // ready_q is set on the same edge the last init word is written, so it
    // is a registered decode of the state with no input-to-output path.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == {ADDR_W{1'b1}}) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                    // Includes an access on the INIT->RUN edge itself.
                    if (ram_cs_i && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
                        drop_cnt_q <= drop_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    ram_rd_pipe #(
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_rd_pipe (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .rd_vld  (rd_en),
        .rd_dat  (rd_dat),
        .rsp_vld (ram_rvalid_o),
        .rsp_dat (ram_data_o)
    );

    assign ram_ready_o = ready_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: three instances (READ_LAT 1, 3, 4) share one bus and a scoreboard each.
// Expected read words are queued with their arrival cycle when a read is driven and popped on rvalid.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ram_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdat;

    logic [31:0] rdat_w  [3];
    logic        rvld_w  [3];
    logic        rdy_w   [3];
    logic [7:0]  drop_w  [3];

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_responder #(.ADDR_W(8), .DATA_W(32), .READ_LAT(1), .INIT_VAL(32'h0)) u_lat1 (
        .clk_i(clk), .rst_n_i(rst_n), .ram_cs_i(cs), .ram_we_i(we), .ram_addr_i(addr),
        .ram_data_i(wdat), .ram_data_o(rdat_w[0]), .ram_rvalid_o(rvld_w[0]),
        .ram_ready_o(rdy_w[0]), .drop_cnt_o(drop_w[0]));

    ram_responder #(.ADDR_W(8), .DATA_W(32), .READ_LAT(3), .INIT_VAL(32'h0)) u_lat3 (
        .clk_i(clk), .rst_n_i(rst_n), .ram_cs_i(cs), .ram_we_i(we), .ram_addr_i(addr),
        .ram_data_i(wdat), .ram_data_o(rdat_w[1]), .ram_rvalid_o(rvld_w[1]),
        .ram_ready_o(rdy_w[1]), .drop_cnt_o(drop_w[1]));

    ram_responder #(.ADDR_W(8), .DATA_W(32), .READ_LAT(4), .INIT_VAL(32'h0)) u_lat4 (
        .clk_i(clk), .rst_n_i(rst_n), .ram_cs_i(cs), .ram_we_i(we), .ram_addr_i(addr),
        .ram_data_i(wdat), .ram_data_o(rdat_w[2]), .ram_rvalid_o(rvld_w[2]),
        .ram_ready_o(rdy_w[2]), .drop_cnt_o(drop_w[2]));

    function automatic int lat(int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(int i, logic [31:0] d, int c);
        exp_t e;
        e.d = d;
        e.c = c;
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qpop(int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic mon(int i);
        exp_t e;
        if (rvld_w[i]) begin
            if (qsize(i) == 0) begin
                check($sformatf("unexpected_rvalid_lat%0d", lat(i)), 64'd1, 64'd0);
            end else begin
                e = qpop(i);
                check($sformatf("rdata_lat%0d", lat(i)), 64'(rdat_w[i]), 64'(e.d));
                check($sformatf("rcycle_lat%0d", lat(i)), 64'(cyc), 64'(e.c));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
        mon(2);
    end

    task automatic wr(logic [7:0] a, logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = a; wdat = d;
    endtask

    // The read is sampled on the next rising edge, cyc+1.
    task automatic rd(logic [7:0] a, logic [31:0] exp_d);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; addr = a;
        for (int i = 0; i < 3; i++) push(i, exp_d, cyc + 1 + lat(i));
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            cs = 1'b0; we = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(string tag);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_ready"},  64'(rdy_w[i]),  64'd0);
            check({tag, "_rvalid"}, 64'(rvld_w[i]), 64'd0);
            check({tag, "_rdata"},  64'(rdat_w[i]), 64'd0);
            check({tag, "_drop"},   64'(drop_w[i]), 64'd0);
        end
    endtask

    task automatic check_drained(string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_pending_lat%0d", tag, lat(i)), 64'(qsize(i)), 64'd0);
        end
    endtask

    initial begin
        int rel;
        int k;
        int n_edge;

        rst_n = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; wdat = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Release with a write to 0x05 pending on every INIT edge: all dropped.
        rst_n = 1'b1; cs = 1'b1; we = 1'b1; addr = 8'h05; wdat = 32'hBAD0_BAD0;
        rel = cyc;
        k = 0;
        for (int j = 0; j < 300 && k < 256; j++) begin
            @(negedge clk);
            k = cyc - rel;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("init_ready_e%0d", k), 64'(rdy_w[i]), 64'(k >= 256));
                if (k == 200) check("drop_mid", 64'(drop_w[i]), 64'd200);
            end
            if (k == 256) begin
                cs = 1'b0; we = 1'b0;
                for (int i = 0; i < 3; i++) check("drop_saturated", 64'(drop_w[i]), 64'd255);
            end
        end
        check("init_edges", 64'(k), 64'd256);

        // Cleared contents, including the address hammered during INIT.
        rd(8'h05, 32'h0);
        rd(8'h80, 32'h0);
        rd(8'hFF, 32'h0);
        idle(6);

        // Write then read on the very next edge.
        wr(8'h10, 32'hDEAD_BEEF);
        rd(8'h10, 32'hDEAD_BEEF);
        idle(6);

        // Top address does not alias onto address 0.
        wr(8'hFF, 32'h1234_5678);
        rd(8'hFF, 32'h1234_5678);
        rd(8'h00, 32'h0);
        idle(6);

        // Back-to-back reads: arrival cycles in the scoreboard enforce no bubbles.
        wr(8'h00, 32'h0000_000A);
        wr(8'h01, 32'h0000_000B);
        wr(8'h02, 32'h0000_000C);
        rd(8'h00, 32'h0000_000A);
        rd(8'h01, 32'h0000_000B);
        rd(8'h02, 32'h0000_000C);
        idle(8);
        check_drained("burst");
        for (int i = 0; i < 3; i++) begin
            check("hold_rdata",  64'(rdat_w[i]), 64'h0000_000C);
            check("hold_rvalid", 64'(rvld_w[i]), 64'd0);
            check("run_drop",    64'(drop_w[i]), 64'd255);
        end

        // Read at edge N, reset sampled at edge N+2: only the 1-cycle instance returns.
        @(negedge clk);
        cs = 1'b1; we = 1'b0; addr = 8'h10;
        n_edge = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (lat(i) < 2) push(i, 32'hDEAD_BEEF, n_edge + lat(i));
        end
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_outputs("midreset");
        check_drained("midreset");

        // Restart: only access is on the INIT->RUN edge, which still counts as dropped.
        rst_n = 1'b1;
        rel = cyc;
        k = 0;
        for (int j = 0; j < 300 && k < 256; j++) begin
            @(negedge clk);
            k = cyc - rel;
            if (k == 255) begin
                for (int i = 0; i < 3; i++) check("restart_ready_e255", 64'(rdy_w[i]), 64'd0);
                cs = 1'b1; we = 1'b0; addr = 8'h00;
            end
            if (k == 256) begin
                cs = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    check("restart_ready_e256", 64'(rdy_w[i]), 64'd1);
                    check("edge_drop", 64'(drop_w[i]), 64'd1);
                end
            end
        end
        idle(7);

        // INIT re-swept the array.
        rd(8'h10, 32'h0);
        rd(8'hFF, 32'h0);
        idle(8);
        check_drained("final");
        for (int i = 0; i < 3; i++) check("final_ready", 64'(rdy_w[i]), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
